// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch sequencer.
//   fetch_state_t    : FS_REQ (may issue a request) / FS_WAIT (one request outstanding)
//   DEFAULT_RESET_PC : default PC after reset
//   INSTR_W          : instruction word width
//   sat_inc16        : saturating 16-bit increment used by the drop counter
package fetch_pkg;

    typedef enum logic [0:0] {
        FS_REQ  = 1'b0,
        FS_WAIT = 1'b1
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int          INSTR_W          = 32;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        logic [15:0] r;
        if (v == 16'hFFFF) begin
            r = v;
        end else begin
            r = v + 16'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fetch_outbuf.sv
// fetch_outbuf: 1-entry output register between fetch and decode.
//   clk, rst      : clock, synchronous active-high reset
//   load_i        : capture load_pc_i/load_instr_i and mark valid
//   flush_i       : drop the held entry (redirect), wins over load
//   stall_i       : decode cannot accept this cycle
//   valid_o/pc_o/instr_o : held entry
//   free_o        : entry is empty or is being consumed this cycle
module fetch_outbuf
    import fetch_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic               flush_i,
    input  logic               stall_i,
    input  logic [ADDR_W-1:0]  load_pc_i,
    input  logic [INSTR_W-1:0] load_instr_i,
    output logic               valid_o,
    output logic [ADDR_W-1:0]  pc_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic               free_o
);

    logic               valid_q;
    logic [ADDR_W-1:0]  pc_q;
    logic [INSTR_W-1:0] instr_q;

    // Output register: reset, flush, load, or consume; pc/instr hold when emptied.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= '0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            pc_q    <= load_pc_i;
            instr_q <= load_instr_i;
        end else if (valid_q && !stall_i) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_q;
        end
    end

    assign free_o  = !valid_q || !stall_i;
    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign instr_o = instr_q;

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer with a single outstanding imem request.
//   clk, rst                   : clock, synchronous active-high reset
//   redirect, redirect_target  : taken branch/jump and its target (low 2 bits ignored)
//   stall                      : decode back-pressure on the output register
//   imem_req/addr/gnt          : request channel (addr = pc)
//   imem_rvalid/rdata          : response channel, one response per grant
//   if_valid/if_pc/if_instr    : instruction handed to decode
//   drop_cnt                   : saturating count of responses discarded by redirects
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          ADDR_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_target,
    input  logic               stall,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               if_valid,
    output logic [ADDR_W-1:0]  if_pc,
    output logic [INSTR_W-1:0] if_instr,
    output logic [15:0]        drop_cnt
);

    localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] PC_RESET = ADDR_W'(RESET_PC);

    fetch_state_t      state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] req_pc_q;
    logic              kill_q;
    logic [15:0]       drop_cnt_q;

    logic              free_s;
    logic              load_s;
    logic [ADDR_W-1:0] target_s;

    assign target_s  = {redirect_target[ADDR_W-1:2], 2'b00};
    assign imem_req  = (state_q == FS_REQ) && free_s && !redirect && !rst;
    assign imem_addr = pc_q;
    // A response is delivered only if it is not stale and no redirect lands this cycle.
    assign load_s    = (state_q == FS_WAIT) && imem_rvalid && !kill_q && !redirect;
    assign drop_cnt  = drop_cnt_q;

    // Fetch FSM: PC, outstanding-request bookkeeping, stale-response kill and drop count.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FS_REQ;
            pc_q       <= PC_RESET;
            req_pc_q   <= PC_RESET;
            kill_q     <= 1'b0;
            drop_cnt_q <= 16'h0000;
        end else if (redirect) begin
            pc_q <= target_s;
            if (state_q == FS_WAIT) begin
                if (imem_rvalid) begin
                    // The outstanding response is consumed right here, so nothing is left to kill.
                    drop_cnt_q <= sat_inc16(drop_cnt_q);
                    kill_q     <= 1'b0;
                    state_q    <= FS_REQ;
                end else begin
                    kill_q <= 1'b1;
                end
            end else begin
                state_q <= FS_REQ;
            end
        end else begin
            case (state_q)
                FS_REQ: begin
                    if (imem_req && imem_gnt) begin
                        req_pc_q <= pc_q;
                        state_q  <= FS_WAIT;
                    end else begin
                        state_q <= FS_REQ;
                    end
                end
                FS_WAIT: begin
                    if (imem_rvalid && kill_q) begin
                        drop_cnt_q <= sat_inc16(drop_cnt_q);
                        kill_q     <= 1'b0;
                        state_q    <= FS_REQ;
                    end else if (imem_rvalid) begin
                        pc_q    <= req_pc_q + PC_STEP;
                        state_q <= FS_REQ;
                    end else begin
                        state_q <= FS_WAIT;
                    end
                end
                default: begin
                    state_q <= FS_REQ;
                end
            endcase
        end
    end

    fetch_outbuf #(
        .ADDR_W (ADDR_W)
    ) u_outbuf (
        .clk          (clk),
        .rst          (rst),
        .load_i       (load_s),
        .flush_i      (redirect),
        .stall_i      (stall),
        .load_pc_i    (req_pc_q),
        .load_instr_i (imem_rdata),
        .valid_o      (if_valid),
        .pc_o         (if_pc),
        .instr_o      (if_instr),
        .free_o       (free_s)
    );

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic [15:0] drop_cnt;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t sb[$];

    fetch_ctrl #(
        .RESET_PC (32'h0000_0000),
        .ADDR_W   (32)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .stall           (stall),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_gnt        (imem_gnt),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .if_valid        (if_valid),
        .if_pc           (if_pc),
        .if_instr        (if_instr),
        .drop_cnt        (drop_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hC0DE_5A00;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pop the scoreboard and compare against the output register.
    task automatic check_out(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s_sb_empty observed=0 expected=1", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_valid"}, {31'd0, if_valid}, 32'd1);
            chk({tag, "_pc"}, if_pc, e.pc);
            chk({tag, "_instr"}, if_instr, e.instr);
        end
    endtask

    // Called right after a negedge with the FSM in FS_REQ; ends at the negedge after delivery.
    task automatic fetch(input logic [31:0] a, input int gdly, input int rdly);
        for (int i = 0; i < gdly; i++) begin
            #1;
            chk("req_wait_gnt", {31'd0, imem_req}, 32'd1);
            chk("addr_wait_gnt", imem_addr, a);
            @(negedge clk);
        end
        #1;
        chk("req", {31'd0, imem_req}, 32'd1);
        chk("addr", imem_addr, a);
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0;
        for (int i = 1; i < rdly; i++) begin
            #1;
            chk("req_in_wait", {31'd0, imem_req}, 32'd0);
            @(negedge clk);
        end
        imem_rvalid = 1'b1;
        imem_rdata  = instr_of(a);
        sb.push_back('{pc: a, instr: instr_of(a)});
        @(negedge clk);
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        check_out("deliver");
    endtask

    initial begin
        rst             = 1'b1;
        redirect        = 1'b0;
        redirect_target = 32'h0;
        stall           = 1'b0;
        imem_gnt        = 1'b0;
        imem_rvalid     = 1'b0;
        imem_rdata      = 32'h0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_if_pc", if_pc, 32'h0);
        chk("rst_if_instr", if_instr, 32'h0);
        chk("rst_drop", {16'd0, drop_cnt}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Sequential fetch, then a delayed grant with a slower response
        fetch(32'h0, 0, 1);
        fetch(32'h4, 2, 2);

        // Stall while holding 0x4
        stall = 1'b1;
        #1;
        chk("stall_req0", {31'd0, imem_req}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            chk("stall_valid", {31'd0, if_valid}, 32'd1);
            chk("stall_pc", if_pc, 32'h4);
            chk("stall_instr", if_instr, instr_of(32'h4));
            chk("stall_req", {31'd0, imem_req}, 32'd0);
        end
        stall = 1'b0;
        fetch(32'h8, 0, 1);

        // Redirect while waiting; stale response arrives two cycles after grant
        #1;
        chk("rdw_addr", imem_addr, 32'hC);
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt        = 1'b0;
        redirect        = 1'b1;
        redirect_target = 32'h0000_0103;
        #1;
        chk("rdw_req", {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        redirect    = 1'b0;
        chk("rdw_valid", {31'd0, if_valid}, 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_BAD0;
        @(negedge clk);
        imem_rvalid = 1'b0;
        chk("rdw_drop", {16'd0, drop_cnt}, 32'd1);
        chk("rdw_valid2", {31'd0, if_valid}, 32'd0);
        #1;
        chk("rdw_next_req", {31'd0, imem_req}, 32'd1);
        chk("rdw_next_addr", imem_addr, 32'h100);

        // Redirect in the same cycle as the response
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt        = 1'b0;
        imem_rvalid     = 1'b1;
        imem_rdata      = 32'hBAD1_BAD1;
        redirect        = 1'b1;
        redirect_target = 32'h0000_0200;
        @(negedge clk);
        imem_rvalid = 1'b0;
        redirect    = 1'b0;
        chk("rsame_drop", {16'd0, drop_cnt}, 32'd2);
        chk("rsame_valid", {31'd0, if_valid}, 32'd0);
        #1;
        chk("rsame_req", {31'd0, imem_req}, 32'd1);
        chk("rsame_addr", imem_addr, 32'h200);

        // Redirect in FS_REQ with a grant present: no request that cycle
        redirect        = 1'b1;
        redirect_target = 32'h0000_0302;
        imem_gnt        = 1'b1;
        #1;
        chk("rreq_req", {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        redirect = 1'b0;
        imem_gnt = 1'b0;
        fetch(32'h300, 0, 1);

        // Address wrap
        redirect        = 1'b1;
        redirect_target = 32'hFFFF_FFFF;
        @(negedge clk);
        redirect = 1'b0;
        fetch(32'hFFFF_FFFC, 0, 1);
        #1;
        chk("wrap_req", {31'd0, imem_req}, 32'd1);
        chk("wrap_addr", imem_addr, 32'h0);

        // Reset while waiting
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0;
        rst      = 1'b1;
        #1;
        chk("mrst_req_during", {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_valid", {31'd0, if_valid}, 32'd0);
        chk("mrst_drop", {16'd0, drop_cnt}, 32'd0);
        chk("mrst_if_pc", if_pc, 32'h0);
        #1;
        chk("mrst_req", {31'd0, imem_req}, 32'd1);
        chk("mrst_addr", imem_addr, 32'h0);
        chk("sb_drained", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
